obi_protocol_checker: RTL and testbench
=======================================

OBI_PROTOCOL_CHECKER -- requirements
Module: obi_protocol_checker

Interface
REQ-001 Parameter ADDR_W, default 32, data-bus address width.
REQ-002 Parameter MAX_OUTSTANDING, default 2, range 1..8, accepted transactions awaiting rvalid.
REQ-003 Parameter LAT_W, default 16, width of cycle stamp and latency values.
REQ-004 Parameter TIMEOUT_CYCLES, default 256, gnt-to-rvalid limit; SHALL be < 2**LAT_W.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 clear_i  in  1  synchronous clear of sticky errors, counters, max latency.
REQ-008 data_req_o_mon  in  1  observed OBI request.
REQ-009 data_gnt_i_mon  in  1  observed OBI grant.
REQ-010 data_rvalid_i_mon  in  1  observed OBI response valid.
REQ-011 data_addr_o_mon  in  ADDR_W  observed address.
REQ-012 data_we_o_mon  in  1  observed write enable.
REQ-013 data_be_o_mon  in  4  observed byte enables.
REQ-014 err_vec_o  out  6  sticky error bits, indices per REQ-024.
REQ-015 err_pulse_o  out  1  one-cycle pulse on any newly set error bit.
REQ-016 outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
REQ-017 txn_count_o  out  32  completed transactions (rvalid count), wraps modulo 2**32.
REQ-018 max_latency_o  out  LAT_W  largest gnt-to-rvalid latency seen.

Function
REQ-019 Address-phase FSM SHALL have states A_IDLE and A_WAIT_GNT; A_IDLE->A_WAIT_GNT when req=1 and gnt=0; A_WAIT_GNT->A_IDLE on req&gnt; req&gnt in A_IDLE stays A_IDLE.
REQ-020 On entering A_WAIT_GNT the checker SHALL capture addr, we, be; while in A_WAIT_GNT any change in these while req=1 sets ERR_ADDR_CHANGE.
REQ-021 req falling to 0 in A_WAIT_GNT without gnt SHALL set ERR_REQ_DROP and return to A_IDLE.
REQ-022 Outstanding count SHALL update as count + (req&gnt) - rvalid in the same cycle; gnt and rvalid together leave count unchanged.
REQ-023 rvalid with count==0 SHALL set ERR_RVALID_ORPHAN and not decrement; req&gnt with count==MAX_OUTSTANDING and no rvalid SHALL set ERR_OVERFLOW and not increment.
REQ-024 Error indices: 0 ERR_RVALID_ORPHAN, 1 ERR_REQ_DROP, 2 ERR_ADDR_CHANGE, 3 ERR_OVERFLOW, 4 ERR_TIMEOUT, 5 ERR_MISALIGNED.
REQ-025 req with be not one of 4'b0001<<n, 4'b0011/4'b1100, 4'b1111 SHALL set ERR_MISALIGNED (covers word at addr[1:0]!=0 and halfword at offset 3).
REQ-026 Errors SHALL be sticky until clear_i or reset; err_pulse_o=1 for exactly the cycle after a bit transitions 0->1.
REQ-027 clear_i SHALL take priority over same-cycle error setting and counter updates; outstanding count and FSM SHALL NOT be cleared.

Reset
REQ-028 On rst_n=0: err_vec_o=0, err_pulse_o=0, outstanding_o=0, txn_count_o=0, max_latency_o=0, FSM=A_IDLE, stamp FIFO empty, cycle counter 0.
REQ-029 Reset mid-transaction SHALL discard all in-flight tracking; rvalid after reset release with count 0 SHALL flag ERR_RVALID_ORPHAN.

Configuration
REQ-030 With OBI_CHK_LATENCY_EN defined: a free-running LAT_W cycle counter stamps each accepted grant into a MAX_OUTSTANDING-deep FIFO; on rvalid latency = (now - head stamp) mod 2**LAT_W, max_latency_o updated if greater, head popped.
REQ-031 With OBI_CHK_LATENCY_EN defined: head age >= TIMEOUT_CYCLES SHALL set ERR_TIMEOUT once per head entry.
REQ-032 Without OBI_CHK_LATENCY_EN: no counter or FIFO instantiated, max_latency_o tied 0, ERR_TIMEOUT never set.

Structure
REQ-033 Package obi_chk_pkg SHALL hold the error index enum, ERR_W=6, and the address-FSM state typedef.
REQ-034 Stamp storage SHALL be sub-module obi_chk_ts_fifo (parametrised depth/width, push, pop, head, empty, full), instantiated only under OBI_CHK_LATENCY_EN.

Verification
REQ-035 req=1 at T, gnt=1 at T+2, rvalid at T+5 -> no errors, outstanding 1 from T+3 to T+5, txn_count_o=1, max_latency_o=3.
REQ-036 req=1, addr 0x100 changes to 0x104 before gnt -> err_vec_o[2]=1, err_pulse_o high one cycle.
REQ-037 MAX_OUTSTANDING=2, three grants without rvalid -> err_vec_o[3]=1, outstanding_o stays 2.
REQ-038 rvalid with no prior grant -> err_vec_o[0]=1; then clear_i -> err_vec_o=0.
REQ-039 be=4'b0110 with req -> err_vec_o[5]=1; be=4'b1100 -> no error.
REQ-040 Latency build, TIMEOUT_CYCLES=8, grant then no rvalid for 8 cycles -> err_vec_o[4]=1 exactly once; counter wrap across 2**LAT_W yields correct latency.

Source files
------------

// File: rtl/obi_chk_pkg.sv
// Shared types and helpers for the OBI protocol checker.
// Latency/timeout tracking is optional and enabled with OBI_CHK_LATENCY_EN.
package obi_chk_pkg;

   localparam int unsigned ERR_W = 6;

   typedef enum logic [2:0] {
      ERR_RVALID_ORPHAN = 3'd0,
      ERR_REQ_DROP      = 3'd1,
      ERR_ADDR_CHANGE   = 3'd2,
      ERR_OVERFLOW      = 3'd3,
      ERR_TIMEOUT       = 3'd4,
      ERR_MISALIGNED    = 3'd5
   } err_idx_e;

   typedef logic [0:0] a_state_t;
   localparam a_state_t A_IDLE     = 1'b0;
   localparam a_state_t A_WAIT_GNT = 1'b1;

   // Byte, aligned halfword or full word; anything else is misaligned.
   function automatic logic be_legal(input logic [3:0] be);
      logic ok;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/obi_chk_ts_fifo.sv
// Grant-stamp FIFO for the latency build: holds one cycle stamp per outstanding transaction.
module obi_chk_ts_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CNT_W'(DEPTH));
   assign head_o    = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   // Storage, pointers and occupancy; a full FIFO may push and pop together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/obi_protocol_checker.sv
// Passive OBI data-bus monitor: sticky protocol errors, outstanding/transaction counts and,
// with OBI_CHK_LATENCY_EN defined, grant-to-rvalid latency tracking and timeout detection.
module obi_protocol_checker
   import obi_chk_pkg::*;
#(
   parameter  int unsigned ADDR_W          = 32,
   parameter  int unsigned MAX_OUTSTANDING = 2,
   parameter  int unsigned LAT_W           = 16,
   parameter  int unsigned TIMEOUT_CYCLES  = 256,
   localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              data_req_o_mon,
   input  logic              data_gnt_i_mon,
   input  logic              data_rvalid_i_mon,
   input  logic [ADDR_W-1:0] data_addr_o_mon,
   input  logic              data_we_o_mon,
   input  logic [3:0]        data_be_o_mon,
   output logic [ERR_W-1:0]  err_vec_o,
   output logic              err_pulse_o,
   output logic [CNT_W-1:0]  outstanding_o,
   output logic [31:0]       txn_count_o,
   output logic [LAT_W-1:0]  max_latency_o
);
   if ((64'(TIMEOUT_CYCLES) >= (64'd1 << LAT_W)) ||
       (MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 8)) begin : g_bad_cfg
      $error("obi_protocol_checker: illegal parameter combination");
   end

   a_state_t          state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ERR_W-1:0]  err_q, err_d, err_set_s;
   logic              pulse_q, pulse_d;
   logic [31:0]       txn_q, txn_d;
   logic [LAT_W-1:0]  max_lat_q, max_lat_d;
   logic              acc_s, orphan_s, overflow_s, accept_s, retire_s;
   logic              timeout_hit_s;
   logic [LAT_W-1:0]  lat_s;

`ifdef OBI_CHK_LATENCY_EN
   logic [LAT_W-1:0] now_q;
   logic [LAT_W-1:0] head_s;
   logic             empty_s;
   logic             full_unused_s;
   logic             to_seen_q;

   obi_chk_ts_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(LAT_W)) u_ts_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept_s),
      .data_i  (now_q),
      .pop_i   (retire_s),
      .head_o  (head_s),
      .empty_o (empty_s),
      .full_o  (full_unused_s)
   );

   // Head age doubles as the latency on the retiring cycle; arithmetic wraps mod 2**LAT_W.
   assign lat_s         = now_q - head_s;
   assign timeout_hit_s = !empty_s && !to_seen_q && (lat_s >= LAT_W'(TIMEOUT_CYCLES));

   // Free-running stamp counter and per-head timeout latch, rearmed when the head pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now_q     <= '0;
         to_seen_q <= 1'b0;
      end else begin
         now_q     <= now_q + LAT_W'(1);
         to_seen_q <= retire_s ? 1'b0 : (to_seen_q | timeout_hit_s);
      end
   end
`else
   assign lat_s         = '0;
   assign timeout_hit_s = 1'b0;
`endif

   // Address-phase FSM and request capture while waiting for grant.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      case (state_q)
         A_IDLE: begin
            if (data_req_o_mon && !data_gnt_i_mon) begin
               state_d = A_WAIT_GNT;
               addr_d  = data_addr_o_mon;
               we_d    = data_we_o_mon;
               be_d    = data_be_o_mon;
            end else begin
               state_d = A_IDLE;
            end
         end
         A_WAIT_GNT: begin
            if (!data_req_o_mon || data_gnt_i_mon) begin
               state_d = A_IDLE;
            end else begin
               state_d = A_WAIT_GNT;
            end
         end
         default: state_d = A_IDLE;
      endcase
   end

   // Outstanding bookkeeping, error detection and clear-priority updates.
   always_comb begin
      acc_s      = data_req_o_mon && data_gnt_i_mon;
      orphan_s   = data_rvalid_i_mon && (cnt_q == '0);
      overflow_s = acc_s && !data_rvalid_i_mon && (cnt_q == CNT_W'(MAX_OUTSTANDING));
      accept_s   = acc_s && !overflow_s;
      retire_s   = data_rvalid_i_mon && !orphan_s;
      cnt_d      = cnt_q + CNT_W'(accept_s) - CNT_W'(retire_s);

      err_set_s                    = '0;
      err_set_s[ERR_RVALID_ORPHAN] = orphan_s;
      err_set_s[ERR_REQ_DROP]      = (state_q == A_WAIT_GNT) && !data_req_o_mon;
      err_set_s[ERR_ADDR_CHANGE]   = (state_q == A_WAIT_GNT) && data_req_o_mon &&
                                     ((data_addr_o_mon != addr_q) || (data_we_o_mon != we_q) ||
                                      (data_be_o_mon != be_q));
      err_set_s[ERR_OVERFLOW]      = overflow_s;
      err_set_s[ERR_TIMEOUT]       = timeout_hit_s;
      err_set_s[ERR_MISALIGNED]    = data_req_o_mon && !be_legal(data_be_o_mon);

      if (clear_i) begin
         err_d     = '0;
         pulse_d   = 1'b0;
         txn_d     = 32'd0;
         max_lat_d = '0;
      end else begin
         err_d     = err_q | err_set_s;
         pulse_d   = |(err_set_s & ~err_q);
         txn_d     = txn_q + 32'(retire_s);
         max_lat_d = (retire_s && (lat_s > max_lat_q)) ? lat_s : max_lat_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= A_IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= 4'b0000;
         cnt_q     <= '0;
         err_q     <= '0;
         pulse_q   <= 1'b0;
         txn_q     <= 32'd0;
         max_lat_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         pulse_q   <= pulse_d;
         txn_q     <= txn_d;
         max_lat_q <= max_lat_d;
      end
   end

   assign err_vec_o     = err_q;
   assign err_pulse_o   = pulse_q;
   assign outstanding_o = cnt_q;
   assign txn_count_o   = txn_q;
   assign max_latency_o = max_lat_q;

endmodule

// File: tb/tb_obi_protocol_checker.sv
// Directed self-checking bench for obi_protocol_checker (MAX_OUTSTANDING=2, LAT_W=4, TIMEOUT_CYCLES=8).
module tb_obi_protocol_checker;

`ifdef OBI_CHK_LATENCY_EN
   localparam bit LAT_EN = 1'b1;
`else
   localparam bit LAT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_i;
   logic        req, gnt, rvalid, we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [5:0]  err_vec;
   logic        err_pulse;
   logic [1:0]  outstanding;
   logic [31:0] txn_count;
   logic [3:0]  max_lat;

   int tests_run = 0;
   int tests_failed = 0;

   obi_protocol_checker #(
      .ADDR_W(32), .MAX_OUTSTANDING(2), .LAT_W(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .clear_i           (clear_i),
      .data_req_o_mon    (req),
      .data_gnt_i_mon    (gnt),
      .data_rvalid_i_mon (rvalid),
      .data_addr_o_mon   (addr),
      .data_we_o_mon     (we),
      .data_be_o_mon     (be),
      .err_vec_o         (err_vec),
      .err_pulse_o       (err_pulse),
      .outstanding_o     (outstanding),
      .txn_count_o       (txn_count),
      .max_latency_o     (max_lat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 1'b0; gnt = 1'b0; rvalid = 1'b0; clear_i = 1'b0;
   endtask

   task automatic do_clear();
      idle();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("clear_err", 32'(err_vec), 32'h0);
      check("clear_txn", txn_count, 32'd0);
      check("clear_maxlat", 32'(max_lat), 32'd0);
   endtask

   initial begin
      idle();
      rst_n = 1'b0; we = 1'b0; addr = 32'h100; be = 4'b1111;
      step(); step();
      check("rst_err", 32'(err_vec), 32'h0);
      check("rst_pulse", 32'(err_pulse), 32'h0);
      check("rst_outst", 32'(outstanding), 32'h0);
      check("rst_txn", txn_count, 32'h0);
      check("rst_maxlat", 32'(max_lat), 32'h0);
      rst_n = 1'b1;
      step();

      // Basic transaction: gnt two cycles after req, rvalid three cycles after gnt
      req = 1'b1; step(); step();
      gnt = 1'b1; step();
      idle();
      check("basic_outst_t3", 32'(outstanding), 32'd1);
      step(); check("basic_outst_t4", 32'(outstanding), 32'd1);
      step(); check("basic_outst_t5", 32'(outstanding), 32'd1);
      rvalid = 1'b1; step(); idle();
      check("basic_outst_done", 32'(outstanding), 32'd0);
      check("basic_txn", txn_count, 32'd1);
      check("basic_err", 32'(err_vec), 32'h0);
      check("basic_maxlat", 32'(max_lat), LAT_EN ? 32'd3 : 32'd0);

      // Aligned upper halfword is legal
      req = 1'b1; gnt = 1'b1; addr = 32'h102; be = 4'b1100; step(); idle();
      rvalid = 1'b1; step(); idle();
      check("hw_err", 32'(err_vec), 32'h0);
      check("hw_txn", txn_count, 32'd2);

      // Address change while waiting for grant
      req = 1'b1; addr = 32'h100; be = 4'b1111; step();
      addr = 32'h104; step();
      check("achg_err", 32'(err_vec), 32'h04);
      check("achg_pulse", 32'(err_pulse), 32'd1);
      gnt = 1'b1; step(); idle();
      check("achg_pulse_once", 32'(err_pulse), 32'd0);
      check("achg_outst", 32'(outstanding), 32'd1);
      rvalid = 1'b1; step(); idle();
      check("achg_txn", txn_count, 32'd3);
      do_clear();

      // Request dropped before grant
      req = 1'b1; addr = 32'h200; step();
      req = 1'b0; step();
      check("drop_err", 32'(err_vec), 32'h02);
      check("drop_pulse", 32'(err_pulse), 32'd1);
      step();
      check("drop_pulse_once", 32'(err_pulse), 32'd0);
      do_clear();

      // Overflow at MAX_OUTSTANDING; clear keeps the outstanding count
      req = 1'b1; gnt = 1'b1; step();
      check("ovf_outst1", 32'(outstanding), 32'd1);
      step();
      check("ovf_outst2", 32'(outstanding), 32'd2);
      check("ovf_no_err_yet", 32'(err_vec), 32'h0);
      step(); idle();
      check("ovf_err", 32'(err_vec), 32'h08);
      check("ovf_outst_sat", 32'(outstanding), 32'd2);
      clear_i = 1'b1; step(); clear_i = 1'b0;
      check("ovf_clear_err", 32'(err_vec), 32'h0);
      check("ovf_clear_outst", 32'(outstanding), 32'd2);
      rvalid = 1'b1; step();
      check("ovf_drain1", 32'(outstanding), 32'd1);
      step(); idle();
      check("ovf_drain0", 32'(outstanding), 32'd0);
      check("ovf_txn", txn_count, 32'd2);
      check("ovf_maxlat", 32'(max_lat), LAT_EN ? 32'd4 : 32'd0);
      do_clear();

      // Orphan rvalid, then clear beats a same-cycle orphan
      rvalid = 1'b1; step();
      check("orph_err", 32'(err_vec), 32'h01);
      check("orph_pulse", 32'(err_pulse), 32'd1);
      check("orph_outst", 32'(outstanding), 32'd0);
      clear_i = 1'b1; step(); idle();
      check("orph_clear_prio", 32'(err_vec), 32'h0);
      check("orph_clear_pulse", 32'(err_pulse), 32'd0);

      // Misaligned byte enables
      req = 1'b1; gnt = 1'b1; be = 4'b0110; step(); idle();
      check("mis_err", 32'(err_vec), 32'h20);
      rvalid = 1'b1; step(); idle();
      check("mis_txn", txn_count, 32'd1);
      be = 4'b1111;
      do_clear();

      // gnt and rvalid together keep the count, even at the limit
      req = 1'b1; gnt = 1'b1; step(); step();
      rvalid = 1'b1; step();
      check("both_outst_full", 32'(outstanding), 32'd2);
      check("both_no_ovf", 32'(err_vec), 32'h0);
      req = 1'b0; gnt = 1'b0; step();
      check("both_drain1", 32'(outstanding), 32'd1);
      step(); idle();
      check("both_drain0", 32'(outstanding), 32'd0);
      check("both_txn", txn_count, 32'd3);
      check("both_maxlat", 32'(max_lat), LAT_EN ? 32'd2 : 32'd0);
      do_clear();

      // Timeout: grant, then no rvalid for 8+ cycles
      req = 1'b1; gnt = 1'b1; step(); idle();
      for (int i = 0; i < 7; i++) step();
      check("to_not_yet", 32'(err_vec), 32'h0);
      step();
      check("to_err", 32'(err_vec), LAT_EN ? 32'h10 : 32'h0);
      check("to_pulse", 32'(err_pulse), LAT_EN ? 32'd1 : 32'd0);
      step();
      check("to_pulse_once", 32'(err_pulse), 32'd0);
      step();
      rvalid = 1'b1; step(); idle();
      check("to_maxlat", 32'(max_lat), LAT_EN ? 32'd11 : 32'd0);
      check("to_outst", 32'(outstanding), 32'd0);
      do_clear();

      // Latency 5 repeated across a 4-bit stamp counter wrap
      for (int t = 0; t < 4; t++) begin
         req = 1'b1; gnt = 1'b1; step(); idle();
         for (int i = 0; i < 4; i++) step();
         rvalid = 1'b1; step(); idle();
      end
      check("wrap_maxlat", 32'(max_lat), LAT_EN ? 32'd5 : 32'd0);
      check("wrap_txn", txn_count, 32'd4);
      check("wrap_err", 32'(err_vec), 32'h0);

      // Reset mid-transaction discards tracking
      req = 1'b1; gnt = 1'b1; step(); idle();
      check("mrst_outst_pre", 32'(outstanding), 32'd1);
      rst_n = 1'b0; #1;
      check("mrst_outst", 32'(outstanding), 32'd0);
      check("mrst_txn", txn_count, 32'd0);
      step(); rst_n = 1'b1;
      rvalid = 1'b1; step(); idle();
      check("mrst_orphan", 32'(err_vec), 32'h01);
      check("mrst_outst_after", 32'(outstanding), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
